axi_rd_dispatcher: RTL and testbench
====================================

# axi_rd_dispatcher

Issuing end of the shared AXI read port for the decompressor array. Arbitrates read-burst requests from `NUM_DECOMPRESSOR` decompressors round-robin, drives one AXI AR channel, and records the one-hot owner of every issued burst in an internal in-order tag queue. Returning R beats are steered to the owning decompressor, and the tag is retired on `rlast`. Sits between the decompressor request ports and the host AXI master interface; a single AXI ID is used, so ordering is purely FIFO.

## Interface
- `NUM_DECOMPRESSOR`, 2, number of requesters (≥2)
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 512, AXI data width
- `TAG_DEPTH`, 8, max outstanding bursts (power of 2)

Clock and reset (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk` in 1 clock
- `rst` in 1 synchronous active-high reset
- `req_valid` in N per-decompressor burst request
- `req_ready` out N one-hot grant/accept, combinational
- `req_addr` in N*ADDR_WIDTH packed, slice i for requester i
- `req_len` in N*8 packed AXI arlen (beats-1)
- `m_axi_arvalid` out 1
- `m_axi_arready` in 1
- `m_axi_araddr` out ADDR_WIDTH
- `m_axi_arlen` out 8
- `m_axi_rvalid` in 1
- `m_axi_rready` out 1
- `m_axi_rdata` in DATA_WIDTH
- `m_axi_rresp` in 2
- `m_axi_rlast` in 1
- `dout_valid` out N one-hot beat valid
- `dout_ready` in N per-decompressor accept
- `dout_data` out DATA_WIDTH shared, = `m_axi_rdata`
- `dout_last` out 1, = `m_axi_rlast`
- `dout_err` out 1, = `m_axi_rresp[1]`
- `outstanding` out log2(TAG_DEPTH)+1, tag queue occupancy

## Operation
- AR slot free = `~m_axi_arvalid | m_axi_arready`. Grant allowed = slot free & `outstanding < TAG_DEPTH`.
- Round-robin: priority starts at index `last_grant+1 mod N`. The first requester with `req_valid` set gets `req_ready` high in the same cycle. At most one `req_ready` is high. `last_grant` is updated on every grant.
- On grant: the AR register loads the granted slice of addr/len, and `m_axi_arvalid` is set next cycle. The one-hot grant is pushed into the tag queue at `wr_ptr`.
- `m_axi_arvalid`/addr/len are held stable until `arready`. A new grant in the same cycle as `arready` replaces them (back-to-back, 1 AR/cycle).
- Tag queue: `TAG_DEPTH` entries of N bits, read/write pointers wrap modulo `TAG_DEPTH`. It uses a true occupancy counter, so all `TAG_DEPTH` entries are usable. Full is `outstanding==TAG_DEPTH`; empty is `outstanding==0`.
- R steering, with `sel` = head tag:
  - `dout_valid = sel & {N{m_axi_rvalid & ~empty}}`
  - `m_axi_rready = ~empty & |(sel & dout_ready)`
- Pop on `rvalid & rready & rlast`.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- Empty queue: `rready=0`, `dout_valid=0`. Stray R beats are never accepted.
- SLVERR/DECERR is forwarded on `dout_err` per beat. It does not alter flow or tag retirement.

## Timing
- Reset values:
  - `m_axi_arvalid=0`, `araddr=0`, `arlen=0`
  - `outstanding=0`, both pointers 0
  - `last_grant=N-1`, so requester 0 has first priority
  - `req_ready`, `m_axi_rready`, `dout_valid` all 0, since the queue is empty and no slot holds a request
- Reset mid-operation discards all outstanding tags and any pending AR. The surrounding system also resets the AXI slave.
- Grant cycle t gives `m_axi_arvalid` at t+1. The earliest R beat for that burst is accepted at t+2.
- Full limit: the grant decision uses registered `outstanding`. A pop in the same cycle does not free a slot until t+1.
- R path is zero-latency, combinational from `rvalid`/`dout_ready` to `rready`/`dout_valid`.

## Test plan
- Reset, then req_valid=2'b11 held: grants in cycles alternate 01,10,01. AR addresses alternate the slices, and arvalid rises one cycle after each grant with arready=1.
- arready=0 for 5 cycles with req_valid=01: exactly one grant. `araddr`/`arlen` stay stable, and no second grant until arready.
- TAG_DEPTH=8, arready=1, rvalid=0: after 8 grants `outstanding=8` and `req_ready=0`. One rlast beat brings it to 7, and a grant reappears the next cycle.
- Issue bursts owner 10 (arlen=3) then 01 (arlen=0): beats 0-3 appear only on `dout_valid[1]`, the next beat only on `dout_valid[0]`. The queue pops after beat 3 and after the single beat.
- dout_ready[owner]=0 with rvalid=1: rready=0 and the beat is held. An rresp=2'b10 beat raises dout_err for that beat only, and the tag still retires on rlast.
- Simultaneous grant and rlast pop at outstanding=4: outstanding stays 4 and the pointers both advance. Also wrap past index 7 and confirm owner order is preserved.

Source files
------------

// File: rtl/axi_rd_dispatcher.sv
// Shared AXI read-port dispatcher: round-robin AR issue from NUM_DECOMPRESSOR requesters,
// in-order one-hot owner tags, and zero-latency R-beat steering back to the owner.
module axi_rd_dispatcher #(
    parameter int NUM_DECOMPRESSOR = 2,
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 512,
    parameter int TAG_DEPTH        = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_DECOMPRESSOR-1:0]        req_valid,
    output logic [NUM_DECOMPRESSOR-1:0]        req_ready,
    input  logic [NUM_DECOMPRESSOR*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_DECOMPRESSOR*8-1:0]      req_len,
    output logic                               m_axi_arvalid,
    input  logic                               m_axi_arready,
    output logic [ADDR_WIDTH-1:0]              m_axi_araddr,
    output logic [7:0]                         m_axi_arlen,
    input  logic                               m_axi_rvalid,
    output logic                               m_axi_rready,
    input  logic [DATA_WIDTH-1:0]              m_axi_rdata,
    input  logic [1:0]                         m_axi_rresp,
    input  logic                               m_axi_rlast,
    output logic [NUM_DECOMPRESSOR-1:0]        dout_valid,
    input  logic [NUM_DECOMPRESSOR-1:0]        dout_ready,
    output logic [DATA_WIDTH-1:0]              dout_data,
    output logic                               dout_last,
    output logic                               dout_err,
    output logic [$clog2(TAG_DEPTH):0]         outstanding
);
    localparam int N  = NUM_DECOMPRESSOR;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);
    localparam logic [N-1:0]  LAST_RST = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]                 last_oh;
    logic [N-1:0]                 prio_mask;
    logic [N-1:0]                 masked_req;
    logic [N-1:0]                 grant_raw;
    logic [N-1:0]                 grant;
    logic                         slot_free;
    logic                         grant_ok;
    logic                         push;
    logic                         pop;
    logic                         empty;
    logic [N-1:0]                 tag_mem [TAG_DEPTH];
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [N-1:0]                 sel;
    logic [N-1:0][ADDR_WIDTH-1:0] lane_addr;
    logic [N-1:0][7:0]            lane_len;
    logic [N-1:0]                 rready_vote;
    logic [ADDR_WIDTH-1:0]        ar_addr_d;
    logic [7:0]                   ar_len_d;
    logic                         unused_rresp;

    assign slot_free = ~m_axi_arvalid | m_axi_arready;
    assign grant_ok  = slot_free & (outstanding != FULL_CNT);
    assign empty     = (outstanding == '0);

    // Requesters strictly above the last winner first; lowest-set-bit isolation picks one.
    assign prio_mask  = ~((last_oh << 1) - N'(1));
    assign masked_req = req_valid & prio_mask;
    assign grant_raw  = (|masked_req) ? (masked_req & (~masked_req + N'(1)))
                                      : (req_valid & (~req_valid + N'(1)));
    assign grant      = grant_raw & {N{grant_ok}};
    assign req_ready  = grant;
    assign push       = |grant;

    assign sel = tag_mem[rd_ptr];

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_addr[i]   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant[i]}};
        assign lane_len[i]    = req_len[i*8 +: 8] & {8{grant[i]}};
        assign dout_valid[i]  = sel[i] & m_axi_rvalid & ~empty;
        assign rready_vote[i] = sel[i] & dout_ready[i];
    end

    always_comb begin
        ar_addr_d = '0;
        ar_len_d  = '0;
        for (int i = 0; i < N; i++) begin
            ar_addr_d = ar_addr_d | lane_addr[i];
            ar_len_d  = ar_len_d | lane_len[i];
        end
    end

    assign m_axi_rready = ~empty & (|rready_vote);
    assign pop          = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    assign dout_data    = m_axi_rdata;
    assign dout_last    = m_axi_rlast;
    assign dout_err     = m_axi_rresp[1];
    assign unused_rresp = m_axi_rresp[0];

    // AR holding register: a new grant overwrites it in the same cycle arready retires it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            last_oh       <= LAST_RST;
        end else begin
            if (push) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= ar_addr_d;
                m_axi_arlen   <= ar_len_d;
                last_oh       <= grant;
            end else if (m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      outstanding <= outstanding + CW'(1);
            else if (pop && !push) outstanding <= outstanding - CW'(1);
        end
    end
endmodule

// File: tb/tb_axi_rd_dispatcher.sv
// Directed bench for axi_rd_dispatcher: arbitration, AR hold, full limit, steering, wrap.
module tb_axi_rd_dispatcher;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int TD = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_len;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic [N-1:0]    dout_valid;
    logic [N-1:0]    dout_ready;
    logic [DW-1:0]   dout_data;
    logic            dout_last;
    logic            dout_err;
    logic [3:0]      outstanding;

    int n_cmp = 0;
    int n_err = 0;

    axi_rd_dispatcher #(
        .NUM_DECOMPRESSOR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .dout_err(dout_err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_valid     = '0;
        req_addr      = '0;
        req_len       = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        dout_ready    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_oh;

        // reset state, stray beat on empty queue
        do_reset();
        settle();
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        check("rst_arlen", 64'(m_axi_arlen), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; dout_ready = 2'b11;
        settle();
        check("stray_rready", 64'(m_axi_rready), 64'd0);
        check("stray_dout_valid", 64'(dout_valid), 64'd0);

        // round-robin with both requesting
        do_reset();
        m_axi_arready = 1'b1;
        req_addr = {64'hB000, 64'hA000};
        req_len  = {8'd5, 8'd2};
        req_valid = 2'b11;
        settle();
        check("rr_grant0", 64'(req_ready), 64'h1);
        check("rr_arvalid_pre", 64'(m_axi_arvalid), 64'd0);
        tick();
        check("rr_arvalid0", 64'(m_axi_arvalid), 64'd1);
        check("rr_araddr0", m_axi_araddr, 64'hA000);
        check("rr_arlen0", 64'(m_axi_arlen), 64'd2);
        settle();
        check("rr_grant1", 64'(req_ready), 64'h2);
        tick();
        check("rr_araddr1", m_axi_araddr, 64'hB000);
        check("rr_arlen1", 64'(m_axi_arlen), 64'd5);
        settle();
        check("rr_grant2", 64'(req_ready), 64'h1);
        tick();
        check("rr_araddr2", m_axi_araddr, 64'hA000);
        check("rr_outstanding", 64'(outstanding), 64'd3);
        req_valid = 2'b00;
        tick();
        check("rr_arvalid_drop", 64'(m_axi_arvalid), 64'd0);

        // AR held while arready low
        do_reset();
        req_addr = {64'h0, 64'hC000};
        req_len  = {8'd0, 8'd7};
        req_valid = 2'b01;
        settle();
        check("hold_grant", 64'(req_ready), 64'h1);
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            check("hold_no_grant", 64'(req_ready), 64'h0);
            check("hold_arvalid", 64'(m_axi_arvalid), 64'd1);
            check("hold_araddr", m_axi_araddr, 64'hC000);
            check("hold_arlen", 64'(m_axi_arlen), 64'd7);
            tick();
        end
        check("hold_outstanding", 64'(outstanding), 64'd1);
        m_axi_arready = 1'b1;
        settle();
        check("hold_regrant", 64'(req_ready), 64'h1);
        tick();
        check("hold_outstanding2", 64'(outstanding), 64'd2);
        req_valid = 2'b00;
        tick();
        check("hold_arvalid_drop", 64'(m_axi_arvalid), 64'd0);

        // fill to TAG_DEPTH, pop one, grant returns the next cycle
        do_reset();
        m_axi_arready = 1'b1;
        req_addr = {64'h0, 64'h1000};
        req_valid = 2'b01;
        for (int c = 0; c < TD; c++) tick();
        settle();
        check("full_outstanding", 64'(outstanding), 64'd8);
        check("full_no_grant", 64'(req_ready), 64'h0);
        tick();
        check("full_arvalid_drop", 64'(m_axi_arvalid), 64'd0);
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; dout_ready = 2'b01;
        settle();
        check("full_pop_rready", 64'(m_axi_rready), 64'd1);
        check("full_pop_dout_valid", 64'(dout_valid), 64'h1);
        check("full_pop_no_grant", 64'(req_ready), 64'h0);
        tick();
        check("full_after_pop", 64'(outstanding), 64'd7);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        settle();
        check("full_regrant", 64'(req_ready), 64'h1);
        tick();
        check("full_refill", 64'(outstanding), 64'd8);
        req_valid = 2'b00;

        // steering: owner 10 (4 beats) then owner 01 (1 beat), with backpressure and error
        do_reset();
        m_axi_arready = 1'b1;
        req_addr = {64'h2000, 64'h3000};
        req_len  = {8'd3, 8'd0};
        req_valid = 2'b10;
        settle();
        check("st_grant_hi", 64'(req_ready), 64'h2);
        tick();
        check("st_araddr_hi", m_axi_araddr, 64'h2000);
        check("st_arlen_hi", 64'(m_axi_arlen), 64'd3);
        req_valid = 2'b01;
        settle();
        check("st_grant_lo", 64'(req_ready), 64'h1);
        tick();
        check("st_araddr_lo", m_axi_araddr, 64'h3000);
        check("st_arlen_lo", 64'(m_axi_arlen), 64'd0);
        check("st_outstanding", 64'(outstanding), 64'd2);
        req_valid = 2'b00;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b0; dout_ready = 2'b01;
        m_axi_rdata = DW'(64'h1111);
        settle();
        check("bp_rready", 64'(m_axi_rready), 64'd0);
        check("bp_dout_valid", 64'(dout_valid), 64'h2);
        tick();
        check("bp_outstanding", 64'(outstanding), 64'd2);
        dout_ready = 2'b11;
        for (int b = 0; b < 4; b++) begin
            m_axi_rdata = DW'(100 + b);
            m_axi_rlast = (b == 3);
            m_axi_rresp = (b == 1) ? 2'b10 : 2'b00;
            settle();
            check("beat_dout_valid", 64'(dout_valid), 64'h2);
            check("beat_rready", 64'(m_axi_rready), 64'd1);
            check("beat_data", dout_data[63:0], 64'(100 + b));
            check("beat_err", 64'(dout_err), 64'(b == 1));
            check("beat_last", 64'(dout_last), 64'(b == 3));
            tick();
            check("beat_outstanding", 64'(outstanding), (b == 3) ? 64'd1 : 64'd2);
        end
        m_axi_rdata = DW'(200); m_axi_rlast = 1'b1; m_axi_rresp = 2'b00;
        settle();
        check("single_dout_valid", 64'(dout_valid), 64'h1);
        check("single_data", dout_data[63:0], 64'd200);
        tick();
        check("single_outstanding", 64'(outstanding), 64'd0);
        settle();
        check("drained_rready", 64'(m_axi_rready), 64'd0);
        check("drained_dout_valid", 64'(dout_valid), 64'h0);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // simultaneous push/pop at occupancy 4, pointers wrap, owner order kept
        do_reset();
        m_axi_arready = 1'b1;
        req_addr = {64'h5000, 64'h4000};
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) tick();
        check("pp_fill", 64'(outstanding), 64'd4);
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; dout_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            check("pp_dout_valid", 64'(dout_valid), 64'(exp_oh));
            check("pp_grant", 64'(req_ready), 64'(exp_oh));
            check("pp_outstanding", 64'(outstanding), 64'd4);
            tick();
        end
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            check("wrap_dout_valid", 64'(dout_valid), 64'(exp_oh));
            check("wrap_outstanding", 64'(outstanding), 64'(4 - k));
            tick();
        end
        check("wrap_empty", 64'(outstanding), 64'd0);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
